// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep sliced adder/subtractor, valid/ready with full backpressure.
// Optional PIPE_ADDER_SATURATE_EN adds in_sat for per-beat signed saturation.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
`ifdef PIPE_ADDER_SATURATE_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = in_sub ? ~in_b : in_b;
  assign c0       = in_sub ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // y carries only the b slices still to be added
    localparam int YW = (STAGES - k) * SW;

    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] x_in;
    logic [YW-1:0]    y_in;
`ifdef PIPE_ADDER_SATURATE_EN
    logic             sat_in;
`endif
    logic [SW:0]      part;
    logic             v_d, v_q;
    logic             c_d, c_q;
    logic [WIDTH-1:0] x_d, x_q;

    if (k == 0) begin : g_src
      assign v_in = in_valid;
      assign c_in = c0;
      assign x_in = in_a;
      assign y_in = b_eff;
`ifdef PIPE_ADDER_SATURATE_EN
      assign sat_in = in_sat;
`endif
    end else begin : g_src
      assign v_in = g_stg[k-1].v_q;
      assign c_in = g_stg[k-1].c_q;
      assign x_in = g_stg[k-1].x_q;
      assign y_in = g_stg[k-1].g_fwd.y_q;
`ifdef PIPE_ADDER_SATURATE_EN
      assign sat_in = g_stg[k-1].g_fwd.sat_q;
`endif
    end

    // x holds finished sum slices below k and untouched A slices above
    always_comb begin
      part = {1'b0, x_in[k*SW +: SW]}
           + {1'b0, y_in[SW-1:0]}
           + {{SW{1'b0}}, c_in};
      x_d = x_in;
      x_d[k*SW +: SW] = part[SW-1:0];
      c_d = part[SW];
      v_d = v_in;
    end

    if (k < LAST) begin : g_fwd
      logic [YW-SW-1:0] y_d, y_q;
`ifdef PIPE_ADDER_SATURATE_EN
      logic sat_d, sat_q;
      always_comb sat_d = sat_in;
`endif
      always_comb y_d = y_in[YW-1:SW];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          x_q <= '0;
          y_q <= '0;
`ifdef PIPE_ADDER_SATURATE_EN
          sat_q <= 1'b0;
`endif
        end else if (en) begin
          v_q <= v_d;
          c_q <= c_d;
          x_q <= x_d;
          y_q <= y_d;
`ifdef PIPE_ADDER_SATURATE_EN
          sat_q <= sat_d;
`endif
        end
      end
    end else begin : g_out
      logic             ovf_d, ovf_q;
      logic [WIDTH-1:0] r_d;

      always_comb begin
        ovf_d = (x_in[WIDTH-1] == y_in[YW-1])
             && (x_d[WIDTH-1] != x_in[WIDTH-1]);
        r_d = x_d;
`ifdef PIPE_ADDER_SATURATE_EN
        if (sat_in && ovf_d)
          r_d = x_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end

      // result fields load only with a real beat so they hold across bubbles
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          x_q   <= '0;
          ovf_q <= 1'b0;
        end else if (en) begin
          v_q <= v_d;
          if (v_d) begin
            c_q   <= c_d;
            x_q   <= r_d;
            ovf_q <= ovf_d;
          end
        end
      end
    end
  end

  assign out_valid = g_stg[LAST].v_q;
  assign out_sum   = g_stg[LAST].x_q;
  assign out_cout  = g_stg[LAST].c_q;
  assign out_ovf   = g_stg[LAST].g_out.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: vector table, stall/reset sequences and random stream
// checked against an arithmetic reference model.
module tb_pipe_adder;

  localparam int W = 32;
  localparam int S = 4;
`ifdef PIPE_ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_sub, in_cin, in_sat;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
`ifdef PIPE_ADDER_SATURATE_EN
    .in_sat    (in_sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        sub, cin;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;

  int          passed = 0;
  int          total  = 0;
  int          n_out  = 0;
  bit          mon_en = 1'b0;
  logic [33:0] expq[$];
  vec_t        tv[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {cout, ovf, sum} from true unsigned and signed sums
  function automatic logic [33:0] model(input logic [31:0] a, b,
                                        input logic sub, cin, sat);
    logic [31:0]     be, r;
    longint unsigned u;
    longint          s, c;
    logic            ovf;
    be  = sub ? ~b : b;
    c   = sub ? 1 : longint'(cin);
    u   = longint'({32'd0, a}) + longint'({32'd0, be}) + c;
    s   = longint'($signed(a)) + longint'($signed(be)) + c;
    r   = u[31:0];
    ovf = (s != longint'($signed(r)));
    if (sat && ovf) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {u[32], ovf, r};
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (expq.size() == 0)
          chk("unexpected_out", {33'd0, out_valid}, 64'd0);
        else
          chk("stream", {30'd0, out_cout, out_ovf, out_sum},
              {30'd0, expq.pop_front()});
      end
      if (in_valid && in_ready)
        expq.push_back(model(in_a, in_b, in_sub, in_cin, SAT && in_sat));
    end
  end

  task automatic beat(input logic [31:0] a, b, input logic sub, cin);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
  endtask

  initial begin
    int acc, n0;
    bit got, now;

    tv[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    tv[1] = '{32'h00FF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0};
    tv[2] = '{32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0};
    tv[3] = '{32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[4] = '{32'd7, 32'd5, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0};
    tv[5] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tv[6] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tv[7] = '{32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; in_cin = 1'b0; in_sat = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_fields", {30'd0, out_cout, out_ovf, out_sum}, 64'd0);
    @(negedge clk) rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      beat(tv[i].a, tv[i].b, tv[i].sub, tv[i].cin);
      step();
      in_valid = 1'b0;
      step(); step();
      chk($sformatf("lat_early%0d", i), {63'd0, out_valid}, 64'd0);
      step();
      chk($sformatf("lat_valid%0d", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d", i), {31'd0, out_cout, out_ovf, out_sum},
          {31'd0, tv[i].co, tv[i].ov, tv[i].s});
      step();
      chk($sformatf("hold%0d", i), {31'd0, out_valid, out_sum},
          {31'd0, 1'b0, tv[i].s});
    end

`ifdef PIPE_ADDER_SATURATE_EN
    in_sat = 1'b1;
    beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    repeat (3) step();
    chk("sat_pos", {31'd0, out_valid, out_ovf, out_sum},
        {31'd0, 1'b1, 1'b1, 32'h7FFF_FFFF});
    beat(32'h8000_0000, 32'h1, 1'b1, 1'b0);
    step(); in_valid = 1'b0;
    repeat (3) step();
    chk("sat_neg", {31'd0, out_valid, out_ovf, out_sum},
        {31'd0, 1'b1, 1'b1, 32'h8000_0000});
    in_sat = 1'b0;
`endif

    // back-to-back beats with a 3-cycle output stall
    mon_en = 1'b1;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          beat(i, 100 * i, 1'b0, 1'b0);
          got = 1'b0;
          for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk) got = in_ready;
            step();
          end
          if (!got) chk("bp_accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
      end
      begin
        logic [31:0] s0;
        got = 1'b0;
        for (int t = 0; t < 20 && !out_valid; t++) step();
        chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
        s0 = out_sum;
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
          #1;
          chk($sformatf("bp_ready_low%0d", t), {63'd0, in_ready}, 64'd0);
          chk($sformatf("bp_stable%0d", t), {31'd0, out_valid, out_sum},
              {31'd0, 1'b1, s0});
          step();
        end
        out_ready = 1'b1;
      end
    join
    for (int j = 0; j < 60 && expq.size() != 0; j++) step();
    chk("bp_count", n_out - n0, 64'd8);
    chk("bp_drained", expq.size(), 64'd0);
    mon_en = 1'b0;

    // reset with a beat on the output and three more in flight
    for (int i = 0; i < 4; i++) begin
      beat(i + 1, 0, 1'b0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_sum", {32'd0, out_sum}, 64'd0);
    @(negedge clk) rst = 1'b0;
    step();
    beat(32'd3, 32'd4, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    now = out_valid;
    step();
    now = now | out_valid;
    step();
    chk("no_stale", {63'd0, now | out_valid}, 64'd0);
    step();
    chk("post_rst", {31'd0, out_valid, out_sum}, {31'd0, 1'b1, 32'd7});
    step();
    chk("post_rst_empty", {63'd0, out_valid}, 64'd0);

    // random stream with random backpressure
    mon_en = 1'b1;
    n0 = n_out;
    acc = 0;
    for (int cyc = 0; cyc < 5000 && acc < 300; cyc++) begin
      logic [31:0] pick[4];
      pick[0] = $urandom; pick[1] = 32'hFFFF_FFFF;
      pick[2] = 32'h7FFF_FFFF; pick[3] = 32'h8000_0000;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a   = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)]
                                           : $urandom;
      in_b   = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)]
                                           : $urandom;
      in_sub = $urandom_range(0, 1) == 1;
      in_cin = $urandom_range(0, 1) == 1;
      in_sat = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 60 && expq.size() != 0; j++) step();
    chk("rand_accepted", acc, 64'd300);
    chk("rand_out_count", n_out - n0, 64'd300);
    chk("rand_drained", expq.size(), 64'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
